// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester IDs, RISC-V load/store funct3 codes and the alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } arb_src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte accesses are never misaligned; unknown encodings are passed through.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The arbiter uses the
// master modport; requesters and the memory model use the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Handshake: a requester raises *_req with stable fields and holds it until
  // it sees the one-cycle *_ack; on that edge it drops req or presents the next
  // request. Fields are latched at grant, so later changes have no effect.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [2:0]        ls_funct3;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_misalign;

  logic              write_mem;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, read_data,
    output if_ack, if_rdata, ls_ack, ls_rdata, ls_misalign,
           write_mem, funct3, write_address, write_data, read_address
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, read_data,
    input  if_ack, if_rdata, ls_ack, ls_rdata, ls_misalign,
           write_mem, funct3, write_address, write_data, read_address
  );

endinterface

// File: rtl/mem_arb_sel.sv
// Grant selection between fetch and load/store. Defining MEM_ARB_RR_EN
// switches from fixed load/store priority to round-robin with a last_grant bit.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     if_req,
  input  logic     ls_req,
  input  logic     grant_en,
  output logic     gnt_valid,
  output arb_src_t gnt_src
);

  assign gnt_valid = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
  arb_src_t last_grant;

  // Misaligned grants count too: any grant the top accepts updates the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_IF;
    end else if (grant_en && gnt_valid) begin
      last_grant <= gnt_src;
    end
  end

  always_comb begin
    gnt_src = SRC_IF;
    if (if_req && ls_req) begin
      gnt_src = (last_grant == SRC_IF) ? SRC_LS : SRC_IF;
    end else if (ls_req) begin
      gnt_src = SRC_LS;
    end
  end
`else
  logic unused_sel;
  assign unused_sel = &{1'b0, clk, rst_n, grant_en};

  always_comb begin
    gnt_src = ls_req ? SRC_LS : SRC_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store: IDLE/BUSY/DONE FSM with
// latched request, latency counter and registered outputs. Option: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus,
  output arb_state_t          dbg_state
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  arb_src_t          src_q, src_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              write_mem_q, write_mem_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic              ls_misalign_q, ls_misalign_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic     gnt_valid;
  arb_src_t gnt_src;
  logic     grant_en;

  mem_arb_sel u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (bus.if_req),
    .ls_req    (bus.ls_req),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_src   (gnt_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    we_d          = we_q;
    f3_d          = f3_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    write_mem_d   = 1'b0;
    if_ack_d      = 1'b0;
    ls_ack_d      = 1'b0;
    ls_misalign_d = 1'b0;
    if_rdata_d    = if_rdata_q;
    ls_rdata_d    = ls_rdata_q;
    grant_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_en = 1'b1;
          src_d    = gnt_src;
          if (gnt_src == SRC_LS && is_misaligned(bus.ls_funct3, bus.ls_addr[1:0])) begin
            // Suppressed access: memory-side outputs keep their old values.
            state_d       = DONE;
            ls_ack_d      = 1'b1;
            ls_misalign_d = 1'b1;
            ls_rdata_d    = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT;
            if (gnt_src == SRC_LS) begin
              we_d        = bus.ls_we;
              f3_d        = bus.ls_funct3;
              addr_d      = bus.ls_addr;
              wdata_d     = bus.ls_wdata;
              write_mem_d = bus.ls_we;
            end else begin
              we_d    = 1'b0;
              f3_d    = F3_W;
              addr_d  = bus.if_addr;
              wdata_d = '0;
            end
          end
        end
      end

      BUSY: begin
        if (we_q) begin
          state_d  = DONE;
          ls_ack_d = 1'b1;
        end else if (cnt_q == 3'd0) begin
          state_d = DONE;
          if (src_q == SRC_LS) begin
            ls_rdata_d = bus.read_data;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = bus.read_data;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q         <= SRC_IF;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= 3'd0;
      write_mem_q   <= 1'b0;
      if_ack_q      <= 1'b0;
      ls_ack_q      <= 1'b0;
      ls_misalign_q <= 1'b0;
      if_rdata_q    <= '0;
      ls_rdata_q    <= '0;
    end else begin
      src_q         <= src_d;
      we_q          <= we_d;
      f3_q          <= f3_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      write_mem_q   <= write_mem_d;
      if_ack_q      <= if_ack_d;
      ls_ack_q      <= ls_ack_d;
      ls_misalign_q <= ls_misalign_d;
      if_rdata_q    <= if_rdata_d;
      ls_rdata_q    <= ls_rdata_d;
    end
  end

  // The latched request doubles as the memory-side output registers.
  assign bus.write_mem     = write_mem_q;
  assign bus.funct3        = f3_q;
  assign bus.write_address = addr_q;
  assign bus.read_address  = addr_q;
  assign bus.write_data    = wdata_q;
  assign bus.if_ack        = if_ack_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_ack        = ls_ack_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.ls_misalign   = ls_misalign_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 for the
// main scenarios and one with MEM_LATENCY=3 for the latency case.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
  arb_state_t st1, st3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(st1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(st3));

  // Memory model: the word at an address is valid only once the address has
  // been stable for MEM_LATENCY cycles; before that it returns a poison value.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  logic [31:0] last1 = '0, last3 = '0;
  int age1 = 0, age3 = 0;
  always @(negedge clk) begin
    if (bus1.read_address !== last1) begin last1 = bus1.read_address; age1 = 0; end
    else if (age1 < 15) age1++;
    if (bus3.read_address !== last3) begin last3 = bus3.read_address; age3 = 0; end
    else if (age3 < 15) age3++;
  end
  assign bus1.read_data = (age1 >= 1) ? mem_word(bus1.read_address) : 32'hBAD0_BAD0;
  assign bus3.read_data = (age3 >= 3) ? mem_word(bus3.read_address) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus1.if_ack, bus1.ls_ack, bus1.ls_misalign, bus1.write_mem, bus1.funct3} !== 7'd0) begin
      errors++; $display("FAIL reset_ctl1 got %b want 0", {bus1.if_ack, bus1.ls_ack, bus1.ls_misalign, bus1.write_mem, bus1.funct3});
    end
    checks++;
    if ({bus1.write_address, bus1.read_address, bus1.write_data, bus1.if_rdata, bus1.ls_rdata} !== 160'd0) begin
      errors++; $display("FAIL reset_bus1 got nonzero outputs want 0");
    end
    checks++;
    if (st1 !== IDLE) begin errors++; $display("FAIL reset_state1 got %0d want %0d", st1, IDLE); end
    checks++;
    if ({bus3.if_ack, bus3.write_mem, bus3.read_address} !== 34'd0 || st3 !== IDLE) begin
      errors++; $display("FAIL reset_dut3 got ack=%b wm=%b ra=%h st=%0d want 0", bus3.if_ack, bus3.write_mem, bus3.read_address, st3);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
    tick();
    checks++;
    if (bus1.read_address !== 32'h10 || bus1.funct3 !== F3_W || bus1.write_mem !== 1'b0) begin
      errors++; $display("FAIL fetch_c1 got ra=%h f3=%b wm=%b want 10 010 0", bus1.read_address, bus1.funct3, bus1.write_mem);
    end
    tick();
    checks++;
    if (bus1.if_ack !== 1'b0) begin errors++; $display("FAIL fetch_c2_ack got %b want 0", bus1.if_ack); end
    tick();
    checks++;
    if (bus1.if_ack !== 1'b1 || bus1.if_rdata !== 32'h0050_0093) begin
      errors++; $display("FAIL fetch_c3 got ack=%b data=%h want 1 00500093", bus1.if_ack, bus1.if_rdata);
    end
    bus1.if_req = 1'b0;
    tick();
    checks++;
    if (bus1.if_ack !== 1'b0 || st1 !== IDLE) begin
      errors++; $display("FAIL fetch_c4 got ack=%b st=%0d want 0 IDLE", bus1.if_ack, st1);
    end
  endtask

  task automatic test_store();
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_funct3 = F3_W;
    bus1.ls_addr = 32'h100; bus1.ls_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (bus1.write_mem !== 1'b1 || bus1.write_address !== 32'h100 ||
        bus1.write_data !== 32'hDEAD_BEEF || bus1.funct3 !== F3_W || bus1.ls_ack !== 1'b0) begin
      errors++; $display("FAIL store_c1 got wm=%b wa=%h wd=%h f3=%b ack=%b want 1 100 deadbeef 010 0",
                         bus1.write_mem, bus1.write_address, bus1.write_data, bus1.funct3, bus1.ls_ack);
    end
    bus1.ls_wdata = 32'h0; // ignored once latched
    tick();
    checks++;
    if (bus1.write_mem !== 1'b0 || bus1.ls_ack !== 1'b1 || bus1.ls_misalign !== 1'b0) begin
      errors++; $display("FAIL store_c2 got wm=%b ack=%b mis=%b want 0 1 0", bus1.write_mem, bus1.ls_ack, bus1.ls_misalign);
    end
    bus1.ls_req = 1'b0;
    tick();
  endtask

  task automatic test_load_half();
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_funct3 = F3_H; bus1.ls_addr = 32'h202;
    tick(); tick(); tick();
    checks++;
    if (bus1.ls_ack !== 1'b1 || bus1.ls_rdata !== 32'hC0DE_0202 || bus1.ls_misalign !== 1'b0) begin
      errors++; $display("FAIL load_half got ack=%b data=%h mis=%b want 1 c0de0202 0", bus1.ls_ack, bus1.ls_rdata, bus1.ls_misalign);
    end
    bus1.ls_req = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_funct3 = F3_W; bus1.ls_addr = 32'h102;
    tick();
    checks++;
    if (bus1.ls_ack !== 1'b1 || bus1.ls_misalign !== 1'b1 || bus1.ls_rdata !== 32'h0 || bus1.write_mem !== 1'b0) begin
      errors++; $display("FAIL misalign_lw got ack=%b mis=%b data=%h wm=%b want 1 1 0 0",
                         bus1.ls_ack, bus1.ls_misalign, bus1.ls_rdata, bus1.write_mem);
    end
    bus1.ls_req = 1'b0;
    tick();
    checks++;
    if (bus1.ls_ack !== 1'b0 || bus1.ls_misalign !== 1'b0 || st1 !== IDLE) begin
      errors++; $display("FAIL misalign_after got ack=%b mis=%b st=%0d want 0 0 IDLE", bus1.ls_ack, bus1.ls_misalign, st1);
    end
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_funct3 = F3_H; bus1.ls_addr = 32'h101; bus1.ls_wdata = 32'h55;
    tick();
    checks++;
    if (bus1.ls_ack !== 1'b1 || bus1.ls_misalign !== 1'b1 || bus1.write_mem !== 1'b0) begin
      errors++; $display("FAIL misalign_sh got ack=%b mis=%b wm=%b want 1 1 0", bus1.ls_ack, bus1.ls_misalign, bus1.write_mem);
    end
    bus1.ls_req = 1'b0;
    tick();
    // A byte at an odd address is a normal access.
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_funct3 = F3_BU; bus1.ls_addr = 32'h103;
    tick();
    checks++;
    if (bus1.ls_ack !== 1'b0 || st1 !== BUSY) begin
      errors++; $display("FAIL byte_odd_c1 got ack=%b st=%0d want 0 BUSY", bus1.ls_ack, st1);
    end
    tick(); tick();
    checks++;
    if (bus1.ls_ack !== 1'b1 || bus1.ls_misalign !== 1'b0 || bus1.ls_rdata !== 32'hC0DE_0103) begin
      errors++; $display("FAIL byte_odd_c3 got ack=%b mis=%b data=%h want 1 0 c0de0103", bus1.ls_ack, bus1.ls_misalign, bus1.ls_rdata);
    end
    bus1.ls_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    logic saw_ack;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_funct3 = F3_W;
    bus1.ls_addr = 32'h180; bus1.ls_wdata = 32'h1234_5678;
    tick();
    checks++;
    if (bus1.write_mem !== 1'b1) begin errors++; $display("FAIL rst_store_wm got %b want 1", bus1.write_mem); end
    #1;
    rst_n = 1'b0;
    bus1.ls_req = 1'b0;
    #1;
    checks++;
    if ({bus1.write_mem, bus1.ls_ack, bus1.if_ack, bus1.ls_misalign, bus1.funct3, bus1.write_address, bus1.write_data,
         bus1.read_address, bus1.if_rdata, bus1.ls_rdata} !== 167'd0 || st1 !== IDLE) begin
      errors++; $display("FAIL rst_async got wm=%b ack=%b wa=%h st=%0d want all 0 IDLE", bus1.write_mem, bus1.ls_ack, bus1.write_address, st1);
    end
    tick();
    rst_n = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus1.ls_ack === 1'b1 || bus1.write_mem === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0 || st1 !== IDLE) begin
      errors++; $display("FAIL rst_no_ack got saw=%b st=%0d want 0 IDLE", saw_ack, st1);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:0] exp_q[$];
    logic [0:0] exp_src;
    logic [31:0] cur_ls;
    int gap;
`ifdef MEM_ARB_RR_EN
    exp_q = '{1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b1, 1'b1, 1'b1};
`endif
    bus1.if_req = 1'b1; bus1.if_addr = 32'h30;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_funct3 = F3_W; bus1.ls_addr = 32'h40;
    for (int g = 0; g < 3; g++) begin
      gap = 0;
      cur_ls = bus1.ls_addr;
      do begin tick(); gap++; end while (!(bus1.if_ack || bus1.ls_ack) && gap < 12);
      exp_src = exp_q.pop_front();
      checks++;
      if (!(bus1.if_ack || bus1.ls_ack)) begin
        errors++; $display("FAIL b2b_timeout grant %0d got no ack want ack", g);
      end else if (bus1.ls_ack !== exp_src) begin
        errors++; $display("FAIL b2b_order grant %0d got ls=%b want ls=%b", g, bus1.ls_ack, exp_src);
      end
      checks++;
      if (gap !== ((g == 0) ? 3 : 4)) begin
        errors++; $display("FAIL b2b_spacing grant %0d got %0d want %0d", g, gap, (g == 0) ? 3 : 4);
      end
      checks++;
      if (bus1.ls_ack === 1'b1 && bus1.ls_rdata !== mem_word(cur_ls)) begin
        errors++; $display("FAIL b2b_ls_data got %h want %h", bus1.ls_rdata, mem_word(cur_ls));
      end else if (bus1.if_ack === 1'b1 && bus1.if_rdata !== mem_word(32'h30)) begin
        errors++; $display("FAIL b2b_if_data got %h want %h", bus1.if_rdata, mem_word(32'h30));
      end
      if (bus1.ls_ack === 1'b1) bus1.ls_addr = bus1.ls_addr + 32'd4;
      if (g == 2) bus1.ls_req = 1'b0;
    end
    gap = 0;
    do begin tick(); gap++; end while (bus1.if_ack !== 1'b1 && gap < 12);
    checks++;
    if (bus1.if_ack !== 1'b1 || bus1.if_rdata !== mem_word(32'h30) || gap !== 4) begin
      errors++; $display("FAIL b2b_if_last got ack=%b data=%h gap=%0d want 1 %h 4", bus1.if_ack, bus1.if_rdata, gap, mem_word(32'h30));
    end
    bus1.if_req = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    bus3.if_req = 1'b1; bus3.if_addr = 32'h20;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (bus3.if_ack !== (k == 5)) begin
        errors++; $display("FAIL lat3_ack cycle %0d got %b want %b", k, bus3.if_ack, (k == 5));
      end
      if (k == 4) begin
        checks++;
        if (st3 !== BUSY) begin errors++; $display("FAIL lat3_busy got %0d want %0d", st3, BUSY); end
      end
      if (k == 5) begin
        checks++;
        if (bus3.if_rdata !== mem_word(32'h20)) begin
          errors++; $display("FAIL lat3_data got %h want %h", bus3.if_rdata, mem_word(32'h20));
        end
        bus3.if_req = 1'b0;
      end
    end
  endtask

  initial begin
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.ls_req = 1'b0; bus1.ls_we = 1'b0;
    bus1.ls_funct3 = 3'b000; bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.ls_req = 1'b0; bus3.ls_we = 1'b0;
    bus3.ls_funct3 = 3'b000; bus3.ls_addr = '0; bus3.ls_wdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_load_half();
    test_misaligned();
    test_reset_mid_store();
    test_back_to_back();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
